// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_pkg;
  localparam int WB_N     = 32;            // data width and register count
  localparam int WB_AW    = $clog2(WB_N);  // register address width
  localparam int WB_DEPTH = 4;             // default long-latency buffer depth

  localparam logic [WB_AW-1:0] WB_ADDR_ZERO = '0;

  // One pending register-file write.
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_N-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of pending writes. Exposes the per-entry
// valid bits and addresses so the parent can build the pending-write mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output logic [CW-1:0]                count,
  output wb_entry_t                    head,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][WB_AW-1:0]  entry_addr
);
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;

  // Next-state: push writes the tail slot, pop retires the head slot.
  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) begin
      mem_d[wptr_q]   = push_entry;
      valid_d[wptr_q] = 1'b1;
      wptr_d          = wptr_q + PW'(1);
    end
    if (pop) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = rptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // State registers; reset discards every buffered entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign head        = mem_q[rptr_q];
  assign entry_valid = valid_q;

  // Flatten buffered addresses for the mask decode.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_addr[i] = mem_q[i].addr;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges the fixed-priority ALU writeback and the buffered long-latency
// writeback into the single register-file write port, and exports a mask
// of registers with buffered writes outstanding.
// Optional feature macro: WB_BYPASS_EN -- when defined, a long-latency
// result arriving to an empty buffer with the ALU idle is written directly.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int N     = WB_N,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 aluValid,
  input  logic [$clog2(N)-1:0] aluAddress,
  input  logic [N-1:0]         aluData,
  input  logic                 lsuValid,
  output logic                 lsuReady,
  input  logic [$clog2(N)-1:0] lsuAddress,
  input  logic [N-1:0]         lsuData,
  output logic                 writeEnable,
  output logic [$clog2(N)-1:0] writeAddress,
  output logic [N-1:0]         writeData,
  output logic [N-1:0]         pendingMask
);
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]               fifo_count;
  wb_entry_t                   fifo_head;
  logic [DEPTH-1:0]            fifo_valid;
  logic [DEPTH-1:0][WB_AW-1:0] fifo_addr;
  logic                        alu_eff, lsu_fire, lsu_nz, fifo_empty;
  logic                        bypass, push, pop;
  logic                        we_q, we_d;
  logic [AW-1:0]               waddr_q, waddr_d;
  logic [N-1:0]                wdata_q, wdata_d;

  // Ready follows registered occupancy only, so a full buffer never
  // accepts on the same edge it pops.
  assign lsuReady   = (fifo_count != CW'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign alu_eff    = aluValid && (aluAddress != WB_ADDR_ZERO);
  assign lsu_fire   = lsuValid && lsuReady;
  assign lsu_nz     = lsu_fire && (lsuAddress != WB_ADDR_ZERO);

`ifdef WB_BYPASS_EN
  assign bypass = lsu_nz && fifo_empty && !alu_eff;
`else
  assign bypass = 1'b0;
`endif

  // Writes to register 0 are swallowed; ALU always wins the port.
  assign push = lsu_nz && !bypass;
  assign pop  = !alu_eff && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (CLK),
    .rst_n       (RST_N),
    .push        (push),
    .push_entry  ('{addr: lsuAddress, data: lsuData}),
    .pop         (pop),
    .count       (fifo_count),
    .head        (fifo_head),
    .entry_valid (fifo_valid),
    .entry_addr  (fifo_addr)
  );

  // Port arbitration: ALU, then buffer head, then bypassed LSU; else idle
  // with address/data held.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_eff) begin
      we_d    = 1'b1;
      waddr_d = aluAddress;
      wdata_d = aluData;
    end else if (pop) begin
      we_d    = 1'b1;
      waddr_d = fifo_head.addr;
      wdata_d = fifo_head.data;
    end else if (bypass) begin
      we_d    = 1'b1;
      waddr_d = lsuAddress;
      wdata_d = lsuData;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign writeEnable  = we_q;
  assign writeAddress = waddr_q;
  assign writeData    = wdata_q;

  // Pending mask: OR-decode of every valid buffered destination. The head
  // being popped stays visible until the edge retires it.
  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (fifo_valid[i]) pendingMask[fifo_addr[i]] = 1'b1;
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomised and directed bench for writeback_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_writeback_arbiter;
  localparam int N = 32, AW = 5, DEPTH = 4;

  logic          CLK = 1'b0, RST_N = 1'b0;
  logic          aluValid = 1'b0, lsuValid = 1'b0;
  logic [AW-1:0] aluAddress = '0, lsuAddress = '0;
  logic [N-1:0]  aluData = '0, lsuData = '0;
  logic          lsuReady, writeEnable;
  logic [AW-1:0] writeAddress;
  logic [N-1:0]  writeData, pendingMask;

  writeback_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .aluValid(aluValid), .aluAddress(aluAddress), .aluData(aluData),
    .lsuValid(lsuValid), .lsuReady(lsuReady), .lsuAddress(lsuAddress), .lsuData(lsuData),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .pendingMask(pendingMask)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [AW-1:0] a; logic [N-1:0] d; } ent_t;
  ent_t          q[$];
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  m_data;
  int            n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] m = '0;
    foreach (q[i]) m[q[i].a] = 1'b1;
    return m;
  endfunction

  task automatic check_model();
    chk("we",    {63'd0, writeEnable}, {63'd0, m_we});
    chk("waddr", 64'(writeAddress), 64'(m_addr));
    chk("wdata", 64'(writeData), 64'(m_data));
    chk("ready", {63'd0, lsuReady}, {63'd0, q.size() != DEPTH});
    chk("mask",  64'(pendingMask), 64'(m_mask()));
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model
  // over the next rising edge, and compare at the following falling edge.
  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [N-1:0] ad,
                      input logic lv, input logic [AW-1:0] la, input logic [N-1:0] ld);
    logic alu_eff, fire, byp;
    ent_t e;
    aluValid = av; aluAddress = aa; aluData = ad;
    lsuValid = lv; lsuAddress = la; lsuData = ld;
    alu_eff = av && (aa != 0);
    fire    = lv && (q.size() != DEPTH);
    byp     = 1'b0;
`ifdef WB_BYPASS_EN
    byp = fire && (la != 0) && (q.size() == 0) && !alu_eff;
`endif
    if (alu_eff) begin
      m_we = 1'b1; m_addr = aa; m_data = ad;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_addr = e.a; m_data = e.d;
    end else if (byp) begin
      m_we = 1'b1; m_addr = la; m_data = ld;
    end else begin
      m_we = 1'b0;
    end
    if (fire && (la != 0) && !byp) q.push_back('{la, ld});
    @(negedge CLK);
    check_model();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    aluValid = 1'b0; lsuValid = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("rst_we",    {63'd0, writeEnable}, 64'd0);
    chk("rst_waddr", 64'(writeAddress), 64'd0);
    chk("rst_wdata", 64'(writeData), 64'd0);
    chk("rst_ready", {63'd0, lsuReady}, 64'd1);
    chk("rst_mask",  64'(pendingMask), 64'd0);
    q.delete(); m_we = 1'b0; m_addr = '0; m_data = '0;
    #2 RST_N = 1'b1;
    @(negedge CLK);
    check_model();
  endtask

  initial begin
    int alu_pct, lsu_pct;
    logic [AW-1:0] aa, la;
    @(negedge CLK);
    do_reset();

    // ALU only, one-cycle latency.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    chk("alu_we",   {63'd0, writeEnable}, 64'd1);
    chk("alu_addr", 64'(writeAddress), 64'd5);
    chk("alu_data", 64'(writeData), 64'hDEADBEEF);
    idle();
    chk("idle_hold", 64'(writeAddress), 64'd5);

    // LSU to r7 held off by three ALU cycles.
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h77);
    chk("p7_a", {63'd0, pendingMask[7]}, 64'd1);
    step(1'b1, 5'd2, 32'h22, 1'b0, '0, '0);
    step(1'b1, 5'd3, 32'h33, 1'b0, '0, '0);
    chk("p7_c", {63'd0, pendingMask[7]}, 64'd1);
    idle();
    chk("p7_wr",  64'(writeAddress), 64'd7);
    chk("p7_clr", {63'd0, pendingMask[7]}, 64'd0);

    // Fill under ALU traffic, then drain in order.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'd10, 32'(i), 1'b1, 5'(i), 32'(100 + i));
    chk("full_ready", {63'd0, lsuReady}, 64'd0);
    step(1'b1, 5'd10, 32'h5, 1'b1, 5'd20, 32'h20);  // refused while full
    idle();
    chk("drain1", 64'(writeAddress), 64'd1);
    chk("ready_after_pop", {63'd0, lsuReady}, 64'd1);
    for (int i = 2; i <= 4; i++) begin
      idle();
      chk("drain", 64'(writeAddress), 64'(i));
    end

    // ALU to r0 does not block the buffer; LSU to r0 is swallowed.
    step(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC);
    step(1'b1, 5'd0, 32'hF0F0, 1'b0, '0, '0);
    chk("alu0_pop", 64'(writeAddress), 64'd12);
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hBAD);
    chk("lsu0_we",   {63'd0, writeEnable}, 64'd0);
    chk("lsu0_mask", 64'(pendingMask), 64'd0);

    // Bypass latency.
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
`ifdef WB_BYPASS_EN
    chk("byp_we",   {63'd0, writeEnable}, 64'd1);
    chk("byp_addr", 64'(writeAddress), 64'd9);
    chk("byp_mask", {63'd0, pendingMask[9]}, 64'd0);
`else
    chk("nobyp_we0",  {63'd0, writeEnable}, 64'd0);
    chk("nobyp_mask", {63'd0, pendingMask[9]}, 64'd1);
    idle();
    chk("nobyp_we",   {63'd0, writeEnable}, 64'd1);
    chk("nobyp_addr", 64'(writeAddress), 64'd9);
`endif

    // Reset mid-burst with three entries buffered.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd13, 32'(i), 1'b1, 5'(21 + i), 32'(i));
    chk("pre_rst_mask", 64'(pendingMask), 64'h00E00000);
    do_reset();
    idle();
    chk("post_rst_we", {63'd0, writeEnable}, 64'd0);
    idle();

    // Random traffic with varying ALU/LSU densities.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        alu_pct = $urandom_range(0, 100);
        lsu_pct = $urandom_range(10, 100);
      end
      if (c == 1500) do_reset();
      aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step($urandom_range(0, 99) < alu_pct, aa, $urandom(),
           $urandom_range(0, 99) < lsu_pct, la, $urandom());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
